wb_gpio: RTL



---
 rtl/wb_gpio_pkg.sv | 20 ++
 rtl/gpio_in_cond.sv | 53 +++++
 rtl/wb_gpio.sv | 114 +++++++++++
 3 files changed

// File: rtl/wb_gpio_pkg.sv
// Shared constants for the wb_gpio block: register offsets (word index), index width, pin limit.
package wb_gpio_pkg;

    localparam int REG_IDX_W = 3;
    localparam int MAX_GPIO  = 32;

    localparam logic [REG_IDX_W-1:0] REG_OUT     = 3'd0;
    localparam logic [REG_IDX_W-1:0] REG_SET     = 3'd1;
    localparam logic [REG_IDX_W-1:0] REG_CLR     = 3'd2;
    localparam logic [REG_IDX_W-1:0] REG_DIR     = 3'd3;
    localparam logic [REG_IDX_W-1:0] REG_IN      = 3'd4;
    localparam logic [REG_IDX_W-1:0] REG_RISE_EN = 3'd5;
    localparam logic [REG_IDX_W-1:0] REG_FALL_EN = 3'd6;
    localparam logic [REG_IDX_W-1:0] REG_PEND    = 3'd7;

    function automatic logic [MAX_GPIO-1:0] lane_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/gpio_in_cond.sv
// Per-pin input conditioning: synchroniser chain, plus a debounce filter when
// WB_GPIO_DEBOUNCE_EN is defined.
module gpio_in_cond #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic pin_i,
    output logic level_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
        end
    end

`ifdef WB_GPIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             level_q;

    // Down-counter runs only while the synchronised value disagrees with the
    // filtered level; terminal count on the DEBOUNCE_CYCLES-th disagreeing edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q   <= CNT_LOAD;
            level_q <= 1'b0;
        end else if (sync_q[SYNC_STAGES-1] == level_q) begin
            cnt_q <= CNT_LOAD;
        end else if (cnt_q == '0) begin
            level_q <= sync_q[SYNC_STAGES-1];
            cnt_q   <= CNT_LOAD;
        end else begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign level_o = level_q;
`else
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

    assign level_o = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/wb_gpio.sv
// Wishbone B4 classic GPIO slave with set/clear aliases and edge interrupts.
// Optional input debounce is enabled by defining WB_GPIO_DEBOUNCE_EN.
module wb_gpio
    import wb_gpio_pkg::*;
#(
    parameter int                N_GPIO          = 32,
    parameter int                SYNC_STAGES     = 2,
    parameter logic [N_GPIO-1:0] RESET_OUT       = '0,
    parameter int                DEBOUNCE_CYCLES = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [31:0]       wb_adr_i,
    input  logic [3:0]        wb_sel_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    input  logic [N_GPIO-1:0] gpio_i,
    output logic [N_GPIO-1:0] gpio_o,
    output logic [N_GPIO-1:0] gpio_oe_o,
    output logic              irq_o
);

    logic                 ack_q;
    logic [31:0]          dat_q;
    logic                 irq_q;
    logic [N_GPIO-1:0]    out_q, dir_q, rise_en_q, fall_en_q, pend_q, prev_q;
    logic [N_GPIO-1:0]    in_w;

    logic                 accept, wr;
    logic [REG_IDX_W-1:0] reg_idx;
    logic [MAX_GPIO-1:0]  lane_w;
    logic [N_GPIO-1:0]    wmask, wbits, pend_clr, edge_hit, rd_reg;
    logic                 unused_bits;

    for (genvar g = 0; g < N_GPIO; g++) begin : g_pin
        gpio_in_cond #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cond (
            .clk_i  (clk_i),
            .rst_n_i(rst_n_i),
            .pin_i  (gpio_i[g]),
            .level_o(in_w[g])
        );
    end

    assign accept  = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr      = accept & wb_we_i;
    assign reg_idx = wb_adr_i[4:2];
    assign lane_w  = lane_mask(wb_sel_i);
    assign wmask   = lane_w[N_GPIO-1:0];
    assign wbits   = wb_dat_i[N_GPIO-1:0] & wmask;

    assign edge_hit = (in_w & ~prev_q & rise_en_q) | (~in_w & prev_q & fall_en_q);
    assign pend_clr = (wr && reg_idx == REG_PEND) ? wbits : '0;

    always_comb begin
        rd_reg = '0;
        case (reg_idx)
            REG_OUT, REG_SET, REG_CLR: rd_reg = out_q;
            REG_DIR:                   rd_reg = dir_q;
            REG_IN:                    rd_reg = in_w;
            REG_RISE_EN:               rd_reg = rise_en_q;
            REG_FALL_EN:               rd_reg = fall_en_q;
            REG_PEND:                  rd_reg = pend_q;
            default:                   rd_reg = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ack_q     <= 1'b0;
            dat_q     <= '0;
            irq_q     <= 1'b0;
            out_q     <= RESET_OUT;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            pend_q    <= '0;
            prev_q    <= '0;
        end else begin
            ack_q  <= accept;
            dat_q  <= (accept && !wb_we_i) ? 32'(rd_reg) : '0;
            prev_q <= in_w;
            // A fresh edge outranks a same-cycle clear of that bit.
            pend_q <= (pend_q & ~pend_clr) | edge_hit;
            irq_q  <= |pend_q;
            if (wr) begin
                case (reg_idx)
                    REG_OUT:     out_q     <= (out_q & ~wmask) | wbits;
                    REG_SET:     out_q     <= out_q | wbits;
                    REG_CLR:     out_q     <= out_q & ~wbits;
                    REG_DIR:     dir_q     <= (dir_q & ~wmask) | wbits;
                    REG_RISE_EN: rise_en_q <= (rise_en_q & ~wmask) | wbits;
                    REG_FALL_EN: fall_en_q <= (fall_en_q & ~wmask) | wbits;
                    default:     ;
                endcase
            end
        end
    end

    assign wb_ack_o  = ack_q;
    assign wb_dat_o  = dat_q;
    assign irq_o     = irq_q;
    assign gpio_o    = out_q;
    assign gpio_oe_o = dir_q;

    assign unused_bits = ^{wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i, lane_w};

endmodule
